// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester BRAM arbiter: widths,
// write-enable constants, FSM state encoding and the request record.
package mem_arbiter_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;

    localparam logic [3:0] WEA_FULL = 4'b1111;
    localparam logic [3:0] WEA_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_CAPT
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH,
        OWN_EXEC
    } arb_owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, exec port and single BRAM port seen by the
// arbiter. "slave" is the arbiter side, "master" the surrounding core/memory.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_cancel;
    logic              f_done;
    logic [DATA_W-1:0] f_rdata;

    logic              e_req;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_done;
    logic [DATA_W-1:0] e_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wea;
    logic              mem_enable;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, f_cancel,
        input  e_req, e_we, e_addr, e_wdata,
        input  mem_rdata,
        output f_done, f_rdata, e_done, e_rdata,
        output mem_addr, mem_wdata, mem_wea, mem_enable
    );

    modport master (
        output f_req, f_addr, f_cancel,
        output e_req, e_we, e_addr, e_wdata,
        output mem_rdata,
        input  f_done, f_rdata, e_done, e_rdata,
        input  mem_addr, mem_wdata, mem_wea, mem_enable
    );

endinterface

// File: rtl/mem_req_slot.sv
// One-deep pending-request holder for a single requester. A request is
// captured only when nothing is pending or in flight for this requester;
// 'avail'/'head' expose either the stored request or a same-edge one so
// the arbiter can grant without a wasted cycle.
module mem_req_slot
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     req,
    input  mem_req_t req_info,
    input  logic     busy,
    input  logic     cancel,
    input  logic     take,
    output logic     avail,
    output mem_req_t head
);

    logic     valid_q, valid_d;
    mem_req_t info_q, info_d;
    logic     accept;

    // Decide acceptance, present the oldest request and update the slot.
    always_comb begin
        accept  = req && !valid_q && !busy && !cancel;
        avail   = !cancel && (valid_q || (req && !busy));
        head    = valid_q ? info_q : req_info;
        valid_d = valid_q;
        info_d  = info_q;
        if (accept) begin
            valid_d = 1'b1;
            info_d  = req_info;
        end
        if (take || cancel) begin
            valid_d = 1'b0;
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            info_q  <= '0;
        end else begin
            valid_q <= valid_d;
            info_q  <= info_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter (exec over fetch) sharing one BRAM port with a
// two-cycle read latency. Reads walk ADDR -> WAIT -> CAPT, stores finish
// after ADDR; a pending request is granted on the CAPT exit edge so
// back-to-back accesses have no idle gap.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              store_q, store_d;
    logic              cancelled_q, cancelled_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wea_q, mem_wea_d;
    logic              f_done_q, f_done_d;
    logic              e_done_q, e_done_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] e_rdata_q, e_rdata_d;

    logic     f_busy, e_busy;
    logic     f_avail, e_avail;
    logic     f_take, e_take;
    logic     can_grant;
    mem_req_t f_info, e_info;
    mem_req_t f_head, e_head;
    mem_req_t sel;

    assign f_busy = (state_q != ST_IDLE) && (owner_q == OWN_FETCH);
    assign e_busy = (state_q != ST_IDLE) && (owner_q == OWN_EXEC);

    assign f_info = '{we: 1'b0, addr: bus.f_addr, wdata: '0};
    assign e_info = '{we: bus.e_we, addr: bus.e_addr, wdata: bus.e_wdata};

    mem_req_slot u_fetch_slot (
        .clk      (clk),
        .rstn     (rstn),
        .req      (bus.f_req),
        .req_info (f_info),
        .busy     (f_busy),
        .cancel   (bus.f_cancel),
        .take     (f_take),
        .avail    (f_avail),
        .head     (f_head)
    );

    mem_req_slot u_exec_slot (
        .clk      (clk),
        .rstn     (rstn),
        .req      (bus.e_req),
        .req_info (e_info),
        .busy     (e_busy),
        .cancel   (1'b0),
        .take     (e_take),
        .avail    (e_avail),
        .head     (e_head)
    );

    // Next-state, completion and grant logic; exec wins every grant it asks for.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        store_d     = store_q;
        cancelled_d = cancelled_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wea_d   = WEA_NONE;
        f_done_d    = 1'b0;
        e_done_d    = 1'b0;
        f_rdata_d   = f_rdata_q;
        e_rdata_d   = e_rdata_q;
        f_take      = 1'b0;
        e_take      = 1'b0;
        can_grant   = 1'b0;
        sel         = e_head;

        if (f_busy && bus.f_cancel) begin
            cancelled_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                can_grant = 1'b1;
            end
            ST_ADDR: begin
                if (store_q) begin
                    e_done_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                if (owner_q == OWN_EXEC) begin
                    e_done_d  = 1'b1;
                    e_rdata_d = bus.mem_rdata;
                end else if (!cancelled_d) begin
                    f_done_d  = 1'b1;
                    f_rdata_d = bus.mem_rdata;
                end
                state_d   = ST_IDLE;
                can_grant = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (can_grant && (e_avail || f_avail)) begin
            sel         = e_avail ? e_head : f_head;
            e_take      = e_avail;
            f_take      = !e_avail;
            owner_d     = e_avail ? OWN_EXEC : OWN_FETCH;
            state_d     = ST_ADDR;
            store_d     = sel.we;
            cancelled_d = 1'b0;
            mem_addr_d  = sel.addr;
            mem_wdata_d = sel.wdata;
            mem_wea_d   = sel.we ? WEA_FULL : WEA_NONE;
        end
    end

    // State and registered outputs; reset aborts any access without a done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_FETCH;
            store_q     <= 1'b0;
            cancelled_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wea_q   <= WEA_NONE;
            f_done_q    <= 1'b0;
            e_done_q    <= 1'b0;
            f_rdata_q   <= '0;
            e_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            cancelled_q <= cancelled_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wea_q   <= mem_wea_d;
            f_done_q    <= f_done_d;
            e_done_q    <= e_done_d;
            f_rdata_q   <= f_rdata_d;
            e_rdata_q   <= e_rdata_d;
        end
    end

    assign bus.f_done     = f_done_q;
    assign bus.f_rdata    = f_rdata_q;
    assign bus.e_done     = e_done_q;
    assign bus.e_rdata    = e_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wea    = mem_wea_q;
    assign bus.mem_enable = 1'b1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver pushes expected completions
// per requester, a separate monitor pops them on f_done/e_done.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        bit          we;
        logic [18:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic preload;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] bram [0:1023];
    logic [31:0] rd_s1, rd_s2;

    exp_t        e_q[$];
    logic [31:0] f_q[$];
    logic [31:0] model_mem [int];
    bit          f_busy, e_busy;
    int          f_cool;
    logic [31:0] e_last;
    int          checks_total, checks_passed;

    function automatic logic [31:0] initWord(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return 32'hC0DE0000 ^ 32'(a * 40503);
    endfunction

    function automatic logic [31:0] modelRead(input int a);
        if (model_mem.exists(a)) return model_mem[a];
        return initWord(a);
    endfunction

    // Behavioural BRAM: registered address, data out two edges later.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) bram[i] <= initWord(i);
        end else if (bus.mem_enable) begin
            if (bus.mem_wea == 4'b1111) bram[bus.mem_addr[9:0]] <= bus.mem_wdata;
            rd_s1 <= bram[bus.mem_addr[9:0]];
            rd_s2 <= rd_s1;
        end
    end
    assign bus.mem_rdata = rd_s2;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    task automatic clearInputs();
        bus.f_req = 1'b0; bus.f_addr = '0; bus.f_cancel = 1'b0;
        bus.e_req = 1'b0; bus.e_we = 1'b0; bus.e_addr = '0; bus.e_wdata = '0;
    endtask

    // Drive one cycle of inputs and record what the requesters should get back.
    task automatic applyStimulus(input bit freq, input logic [18:0] faddr, input bit fcancel,
                                 input bit ereq, input bit ewe, input logic [18:0] eaddr,
                                 input logic [31:0] ewdata);
        exp_t x;
        @(negedge clk); #1;
        bus.f_req = freq; bus.f_addr = faddr; bus.f_cancel = fcancel;
        bus.e_req = ereq; bus.e_we = ewe; bus.e_addr = eaddr; bus.e_wdata = ewdata;
        if (fcancel) begin
            f_q.delete();
            f_busy = 1'b0;
            f_cool = 6;
        end else if (freq && !f_busy && f_cool == 0) begin
            f_q.push_back(modelRead(int'(faddr)));
            f_busy = 1'b1;
        end
        if (ereq && !e_busy) begin
            x.we   = ewe;
            x.addr = eaddr;
            x.data = ewe ? ewdata : modelRead(int'(eaddr));
            e_q.push_back(x);
            e_busy = 1'b1;
            if (ewe) model_mem[int'(eaddr)] = ewdata;
        end
    endtask

    // Observe a fixed window after a stimulus edge; index n = cycles after that edge.
    task automatic waitQuiet(input int budget, output int e_lat, output int f_lat,
                             output int e_cnt, output int f_cnt, output int w_cnt);
        e_lat = -1; f_lat = -1; e_cnt = 0; f_cnt = 0; w_cnt = 0;
        for (int n = 0; n <= budget; n++) begin
            @(negedge clk);
            if (bus.e_done) begin e_cnt++; if (e_lat < 0) e_lat = n; end
            if (bus.f_done) begin f_cnt++; if (f_lat < 0) f_lat = n; end
            if (bus.mem_wea != 4'b0000) w_cnt++;
            if (n == 0) begin #1; clearInputs(); end
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_f_done",    32'(bus.f_done),    32'd0);
        checkOutput("rst_e_done",    32'(bus.e_done),    32'd0);
        checkOutput("rst_mem_wea",   32'(bus.mem_wea),   32'd0);
        checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata,      32'd0);
        checkOutput("rst_f_rdata",   bus.f_rdata,        32'd0);
        checkOutput("rst_e_rdata",   bus.e_rdata,        32'd0);
        checkOutput("rst_mem_en",    32'(bus.mem_enable), 32'd1);
    endtask

    // Monitor: pops expectations on every done and polices write strobes.
    initial begin
        exp_t x;
        logic [31:0] fx;
        forever begin
            @(negedge clk);
            if (f_cool > 0) f_cool--;
            if (rstn) begin
                if (bus.f_done || bus.e_done)
                    checkOutput("done_exclusive", 32'(bus.f_done && bus.e_done), 32'd0);
                if (bus.mem_wea != 4'b0000) begin
                    checkOutput("wea_value", 32'(bus.mem_wea), 32'(WEA_FULL));
                    checkOutput("wea_store_pending", 32'(e_q.size() > 0 && e_q[0].we), 32'd1);
                    if (e_q.size() > 0) begin
                        checkOutput("wea_addr", 32'(bus.mem_addr), 32'(e_q[0].addr));
                        checkOutput("wea_data", bus.mem_wdata, e_q[0].data);
                    end
                end
                if (bus.e_done) begin
                    checkOutput("e_done_pending", 32'(e_q.size()), 32'd1);
                    if (e_q.size() > 0) begin
                        x = e_q.pop_front();
                        e_busy = 1'b0;
                        if (x.we) checkOutput("e_store_rdata_held", bus.e_rdata, e_last);
                        else begin
                            checkOutput("e_load_rdata", bus.e_rdata, x.data);
                            e_last = x.data;
                        end
                    end
                end
                if (bus.f_done) begin
                    checkOutput("f_done_pending", 32'(f_q.size()), 32'd1);
                    if (f_q.size() > 0) begin
                        fx = f_q.pop_front();
                        f_busy = 1'b0;
                        checkOutput("f_rdata", bus.f_rdata, fx);
                    end
                end
            end
        end
    end

    // Directed scenarios followed by a randomized mix and a bounded drain.
    initial begin
        int el, fl, ec, fc, wc;
        bit fr, fk, er, ew;
        checks_total = 0; checks_passed = 0;
        f_busy = 1'b0; e_busy = 1'b0; f_cool = 0; e_last = '0;
        rstn = 1'b0; preload = 1'b1;
        clearInputs();
        @(negedge clk); preload = 1'b0;
        @(negedge clk); @(negedge clk);
        checkResetOutputs();
        #1 rstn = 1'b1;

        $display("[TB] fetch read of 0x00010");
        applyStimulus(1, 19'h00010, 0, 0, 0, 19'h0, 32'h0);
        waitQuiet(8, el, fl, ec, fc, wc);
        checkOutput("fetch_latency", 32'(fl), 32'd3);
        checkOutput("fetch_done_count", 32'(fc), 32'd1);
        checkOutput("fetch_no_wea", 32'(wc), 32'd0);
        checkOutput("fetch_no_e_done", 32'(ec), 32'd0);
        checkOutput("fetch_rdata_held", bus.f_rdata, 32'hDEADBEEF);

        $display("[TB] store then load of 0x00020");
        applyStimulus(0, 19'h0, 0, 1, 1, 19'h00020, 32'h12345678);
        waitQuiet(6, el, fl, ec, fc, wc);
        checkOutput("store_latency", 32'(el), 32'd1);
        checkOutput("store_wea_cycles", 32'(wc), 32'd1);
        checkOutput("store_done_count", 32'(ec), 32'd1);
        applyStimulus(0, 19'h0, 0, 1, 0, 19'h00020, 32'h0);
        waitQuiet(8, el, fl, ec, fc, wc);
        checkOutput("load_latency", 32'(el), 32'd3);
        checkOutput("load_rdata", bus.e_rdata, 32'h12345678);

        $display("[TB] simultaneous fetch and exec load");
        applyStimulus(1, 19'h00011, 0, 1, 0, 19'h00030, 32'h0);
        waitQuiet(10, el, fl, ec, fc, wc);
        checkOutput("contend_e_latency", 32'(el), 32'd3);
        checkOutput("contend_f_latency", 32'(fl), 32'd6);

        $display("[TB] second exec request while busy is ignored");
        applyStimulus(0, 19'h0, 0, 1, 0, 19'h00030, 32'h0);
        applyStimulus(0, 19'h0, 0, 1, 0, 19'h00031, 32'h0);
        waitQuiet(8, el, fl, ec, fc, wc);
        checkOutput("busy_e_done_count", 32'(ec), 32'd1);

        $display("[TB] fetch cancelled during WAIT");
        applyStimulus(1, 19'h00018, 0, 0, 0, 19'h0, 32'h0);
        applyStimulus(0, 19'h0, 0, 0, 0, 19'h0, 32'h0);
        applyStimulus(0, 19'h0, 1, 0, 0, 19'h0, 32'h0);
        waitQuiet(8, el, fl, ec, fc, wc);
        checkOutput("cancel_no_f_done", 32'(fc), 32'd0);
        applyStimulus(1, 19'h00040, 0, 0, 0, 19'h0, 32'h0);
        waitQuiet(8, el, fl, ec, fc, wc);
        checkOutput("after_cancel_latency", 32'(fl), 32'd3);
        checkOutput("after_cancel_count", 32'(fc), 32'd1);

        $display("[TB] reset during read WAIT");
        applyStimulus(1, 19'h00010, 0, 0, 0, 19'h0, 32'h0);
        applyStimulus(0, 19'h0, 0, 0, 0, 19'h0, 32'h0);
        @(negedge clk); #1;
        rstn = 1'b0;
        f_q.delete(); e_q.delete();
        f_busy = 1'b0; e_busy = 1'b0; f_cool = 0; e_last = '0;
        @(negedge clk);
        checkResetOutputs();
        #1 rstn = 1'b1;
        waitQuiet(6, el, fl, ec, fc, wc);
        checkOutput("reset_no_f_done", 32'(fc), 32'd0);
        checkOutput("reset_no_e_done", 32'(ec), 32'd0);
        applyStimulus(0, 19'h0, 0, 1, 0, 19'h00030, 32'h0);
        waitQuiet(8, el, fl, ec, fc, wc);
        checkOutput("post_reset_latency", 32'(el), 32'd3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            fr = ($urandom_range(0, 99) < 30) && (f_cool == 0);
            fk = ($urandom_range(0, 99) < 3);
            er = ($urandom_range(0, 99) < 30);
            ew = ($urandom_range(0, 1) == 1);
            applyStimulus(fr, 19'($urandom_range(0, 255)), fk,
                          er, ew, 19'(256 + $urandom_range(0, 255)), $urandom);
        end
        for (int i = 0; i < 40 && (f_busy || e_busy); i++)
            applyStimulus(0, 19'h0, 0, 0, 0, 19'h0, 32'h0);
        checkOutput("drain_fetch", 32'(f_q.size()), 32'd0);
        checkOutput("drain_exec", 32'(e_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
